dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit memory words (power of two, 4..1024).
REQ-002 SHALL have parameter WAIT_STATES, default 2, number of wait cycles inserted per access (0..15).
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous active-low reset.
REQ-006 SHALL have port dmem_req  input  1  single-cycle request pulse from core.
REQ-007 SHALL have port dmem_write  input  1  1 = write, 0 = read, sampled with dmem_req.
REQ-008 SHALL have port dmem_addr  input  32  byte address, sampled with dmem_req.
REQ-009 SHALL have port dmem_write_data  input  32  write data, sampled with dmem_req.
REQ-010 SHALL have port dmem_byte_en  input  4  per-byte write enables, bit i covers data[8i+7:8i].
REQ-011 SHALL have port dmem_read_data  output  32  registered read data, valid while dmem_ready high.
REQ-012 SHALL have port dmem_ready  output  1  one-cycle completion pulse.
REQ-013 SHALL have port dmem_busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port dmem_overrun  output  1  sticky flag, request dropped while busy.
REQ-015 SHALL have port dmem_error  output  1  access error, valid while dmem_ready high.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 IDLE with dmem_req=1 SHALL latch write, addr, data, byte_en at that edge (acceptance edge E0), load wait counter with WAIT_STATES, go WAIT (WAIT_STATES>0) or RESP (WAIT_STATES=0).
REQ-018 WAIT SHALL decrement counter each edge and go RESP on the edge where counter reaches 0; dmem_ready SHALL be high exactly in the cycle following edge E0+WAIT_STATES.
REQ-019 Word index SHALL be dmem_addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap/alias).
REQ-020 Writes SHALL commit on the edge entering RESP, updating only bytes with dmem_byte_en set; byte_en=0000 completes with no change.
REQ-021 Reads SHALL register the full word into dmem_read_data on the edge entering RESP; dmem_read_data SHALL hold its value until the next read completes; writes SHALL not alter it.
REQ-022 RESP SHALL return to IDLE unconditionally on the next edge; dmem_req in the RESP cycle SHALL be treated as arriving while busy.
REQ-023 dmem_req while state is WAIT or RESP SHALL be ignored and SHALL set dmem_overrun, which stays high until reset.
REQ-024 Minimum spacing between accepted requests SHALL be WAIT_STATES+2 cycles.

Reset
REQ-025 reset low at a rising edge SHALL force IDLE, dmem_ready=0, dmem_busy=0, dmem_overrun=0, dmem_error=0, dmem_read_data=0, counter=0.
REQ-026 Memory contents SHALL not be reset.
REQ-027 Reset during WAIT, or at the commit edge, SHALL abandon the access with no write committed and no dmem_ready pulse.

Configuration
REQ-028 With DMEM_MISALIGN_CHECK_EN defined, an access with dmem_addr[1:0]!=0 SHALL complete normally in timing with dmem_error=1 during the dmem_ready cycle, write suppressed, dmem_read_data=0.
REQ-029 Without DMEM_MISALIGN_CHECK_EN, dmem_addr[1:0] SHALL be ignored and dmem_error SHALL be constant 0.

Verification (DEPTH_WORDS=64, WAIT_STATES=2 unless noted)
REQ-030 Write 0x00000019 to addr 100, be=1111, then read 100 -> each dmem_ready pulses 3 cycles after acceptance edge, read data 0x00000019.
REQ-031 Write 0xAABBCCDD to addr 96, then write 0x00000011 be=0001, read 96 -> 0xAABBCC11.
REQ-032 Second dmem_req one cycle after an accepted write to 100 -> ignored, dmem_overrun=1 and stays 1, only one dmem_ready pulse.
REQ-033 Word 100 holds 0x19; write 0x55 to 100, reset low in WAIT -> no dmem_ready, all outputs 0, subsequent read of 100 returns 0x00000019.
REQ-034 Read addr 102 -> with DMEM_MISALIGN_CHECK_EN: dmem_error=1, data 0; without: data of word 100, dmem_error=0.
REQ-035 WAIT_STATES=0: write 0x1234 to addr 256 then read addr 0 -> dmem_ready 1 cycle after each acceptance, read data 0x00001234 (alias).

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
// ----------------------------------------------------------------------------
// Word-organised data memory that answers single-cycle core requests after a
// fixed number of wait states. A request is accepted only in IDLE. The access
// then spends WAIT_STATES cycles in WAIT and ends with a one-cycle RESP, which
// pulses dmem_ready. Writes commit, and read data is registered, on the edge
// that enters RESP. Memory contents are never cleared by reset.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, 4..1024)
//   WAIT_STATES  wait cycles inserted per access (0..15)
//
// Ports
//   clk              sole clock, rising edge
//   reset            synchronous, active-low
//   dmem_req         single-cycle request pulse
//   dmem_write       1 = write, 0 = read (sampled with dmem_req)
//   dmem_addr        byte address; word index = addr[log2(DEPTH)+1:2]
//   dmem_write_data  write data
//   dmem_byte_en     per-byte write enables
//   dmem_read_data   registered read data, held until the next read completes
//   dmem_ready       one-cycle completion pulse
//   dmem_busy        high whenever the FSM is not IDLE
//   dmem_overrun     sticky: a request arrived while busy and was dropped
//   dmem_error       access error, valid with dmem_ready
//
// Build option
//   DMEM_MISALIGN_CHECK_EN  when defined, accesses with addr[1:0] != 0 finish
//                           with dmem_error=1, no write and read data 0.
//                           When undefined, addr[1:0] is ignored and
//                           dmem_error is tied to 0.
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_req,
    input  logic        dmem_write,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_write_data,
    input  logic [3:0]  dmem_byte_en,
    output logic [31:0] dmem_read_data,
    output logic        dmem_ready,
    output logic        dmem_busy,
    output logic        dmem_overrun,
    output logic        dmem_error
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic          overrun_reg;

    // Request fields captured at the acceptance edge.
    logic          write_reg;
    logic [AW+1:0] addr_reg;
    logic [31:0]   wdata_reg;
    logic [3:0]    be_reg;

    // Set on the edge that enters RESP: the access takes effect there.
    logic          commit;

    // Access fields seen at the commit edge. With WAIT_STATES=0 the commit
    // edge is the acceptance edge itself, so the live inputs are used while
    // in IDLE; otherwise the latched copy is used.
    logic          acc_write;
    logic [AW+1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic [AW-1:0] acc_idx;
    logic          acc_mis;
    logic          rd_en;
    logic [3:0]    lane_we;

    // ------------------------------------------------------------------
    // FSM: next state and commit strobe
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (dmem_req) begin
                    cnt_next = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                // Counter reaches 0 on this edge: enter RESP now.
                if (cnt_reg == 4'd1) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (dmem_req && (state_reg != IDLE)) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // Datapath capture; no reset needed, only read after a valid acceptance.
    always_ff @(posedge clk) begin
        if ((state_reg == IDLE) && dmem_req) begin
            write_reg <= dmem_write;
            addr_reg  <= dmem_addr[AW+1:0];
            wdata_reg <= dmem_write_data;
            be_reg    <= dmem_byte_en;
        end
    end

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    always_comb begin
        if (state_reg == IDLE) begin
            acc_write = dmem_write;
            acc_addr  = dmem_addr[AW+1:0];
            acc_wdata = dmem_write_data;
            acc_be    = dmem_byte_en;
        end else begin
            acc_write = write_reg;
            acc_addr  = addr_reg;
            acc_wdata = wdata_reg;
            acc_be    = be_reg;
        end
    end

    assign acc_idx = acc_addr[AW+1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign acc_mis = (acc_addr[1:0] != 2'b00);
`else
    assign acc_mis = 1'b0;
`endif

    // A reset sampled at the commit edge abandons the access.
    assign rd_en = commit && !acc_write;

    // ------------------------------------------------------------------
    // Byte-lane memories with registered read
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH_WORDS];
            logic [7:0] rd_lane_reg;

            assign lane_we[gi] = commit && reset && acc_write
                                 && acc_be[gi] && !acc_mis;

            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    mem_lane[acc_idx] <= acc_wdata[8*gi +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    rd_lane_reg <= 8'd0;
                end else if (rd_en) begin
                    rd_lane_reg <= acc_mis ? 8'd0 : mem_lane[acc_idx];
                end
            end

            assign dmem_read_data[8*gi +: 8] = rd_lane_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Error flag
    // ------------------------------------------------------------------
`ifdef DMEM_MISALIGN_CHECK_EN
    logic error_reg;

    // High only in the RESP cycle of a misaligned access.
    always_ff @(posedge clk) begin
        if (!reset) begin
            error_reg <= 1'b0;
        end else begin
            error_reg <= commit && acc_mis;
        end
    end

    assign dmem_error = error_reg;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{dmem_addr[31:AW+2]};
`else
    assign dmem_error = 1'b0;

    // Byte-offset and alias bits carry no meaning in this build.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{dmem_addr[31:AW+2], acc_addr[1:0]};
`endif

    assign dmem_ready   = (state_reg == RESP);
    assign dmem_busy    = (state_reg != IDLE);
    assign dmem_overrun = overrun_reg;

endmodule
